// File: rtl/floor_display_scan.sv
// Floor indicator driver: captures the elevator floor, tracks the travel
// direction, and scans the floor number onto multiplexed 7-segment digits.
// An out-of-range capture raises err and blinks "E" on every digit.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous active-low reset
//   floor        binary floor number, sampled when floor_valid=1
//   floor_valid  capture strobe
//   seg          registered segment pattern {g,f,e,d,c,b,a}, active-high
//   digit_en     registered one-hot digit enable, bit 0 = least-significant digit
//   dir          registered direction: 00 idle, 01 up, 10 down
//   err          registered out-of-range flag
module floor_display_scan #(
  parameter int unsigned NUM_FLOORS = 10,
  parameter int unsigned FLOOR_W    = 4,
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned BLINK_DIV  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOOR_W-1:0] floor,
  input  logic              floor_valid,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_en,
  output logic [1:0]        dir,
  output logic              err
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned IDX_W   = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned BCD_W   = 4 * DIGITS;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  // One extra bit so NUM_FLOORS == 2**FLOOR_W still compares correctly.
  localparam logic [FLOOR_W:0]   FLOOR_LIM  = (FLOOR_W + 1)'(NUM_FLOORS);

  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  logic [FLOOR_W-1:0] shown;
  dir_t               dir_q;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  logic               in_range;
  logic               scan_wrap;
  logic               frame_wrap;
  logic [BCD_W-1:0]   bcd;
  logic [3:0]         cur_digit;
  logic               cur_lit;
  logic [6:0]         seg_nxt;

  // 7-segment code for one BCD digit; anything else blanks.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign in_range   = {1'b0, floor} < FLOOR_LIM;
  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_wrap && (digit_idx == IDX_LAST);
  assign dir        = dir_q;

  // Binary to BCD by shift-and-add-3 (double dabble).
  always_comb begin
    bcd = '0;
    for (int i = int'(FLOOR_W) - 1; i >= 0; i--) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) begin
          bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
      end
      bcd = {bcd[BCD_W-2:0], shown[i]};
    end
  end

  // Pick the active digit; it is lit if it or any higher digit is nonzero,
  // and digit 0 is always lit so a shown 0 still displays.
  always_comb begin
    cur_digit = 4'd0;
    cur_lit   = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (IDX_W'(d) == digit_idx) begin
        cur_digit = bcd[d*4 +: 4];
        cur_lit   = (d == 0) || ((bcd >> (4 * d)) != '0);
      end
    end
  end

  // Next segment pattern: blinking E in error mode, else the active digit.
  always_comb begin
    seg_nxt = SEG_BLANK;
    if (err) begin
      seg_nxt = blink_on ? SEG_E : SEG_BLANK;
    end else if (cur_lit) begin
      seg_nxt = seg_code(cur_digit);
    end
  end

  // Floor capture, direction and out-of-range tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown <= '0;
      dir_q <= DIR_IDLE;
      err   <= 1'b0;
    end else if (floor_valid) begin
      if (in_range) begin
        shown <= floor;
        err   <= 1'b0;
        if (floor > shown) begin
          dir_q <= DIR_UP;
        end else if (floor < shown) begin
          dir_q <= DIR_DOWN;
        end else begin
          dir_q <= DIR_IDLE;
        end
      end else begin
        err <= 1'b1;
      end
    end
  end

  // Digit scan timing and free-running blink phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (scan_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (frame_wrap) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // Display outputs, reflecting the digit index and state before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg      <= SEG_BLANK;
      digit_en <= '0;
    end else begin
      seg      <= seg_nxt;
      digit_en <= DIGITS'(1) << digit_idx;
    end
  end

endmodule

// File: tb/tb_floor_display_scan.sv
module tb_floor_display_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fl_a, fl_b;
  logic       fv_a, fv_b;
  logic [6:0] seg_a, seg_b;
  logic [1:0] den_a, den_b;
  logic [1:0] dir_a, dir_b;
  logic       err_a, err_b;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  floor_display_scan dut_a (
    .clk(clk), .reset(reset), .floor(fl_a), .floor_valid(fv_a),
    .seg(seg_a), .digit_en(den_a), .dir(dir_a), .err(err_a)
  );

  floor_display_scan #(.NUM_FLOORS(16)) dut_b (
    .clk(clk), .reset(reset), .floor(fl_b), .floor_valid(fv_b),
    .seg(seg_b), .digit_en(den_b), .dir(dir_b), .err(err_b)
  );

  typedef struct {
    logic       sel;   // 0 = default DUT, 1 = NUM_FLOORS=16 DUT
    logic       fv;
    logic [3:0] fl;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [1:0] dir;
    logic       err;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Both DUTs scan with SCAN_DIV=4, DIGITS=2; cyc counts edges since reset release.
  function automatic int exp_idx(input int c);
    return ((c - 1) / 4) % 2;
  endfunction

  function automatic logic exp_blink(input int c);
    return (((c - 1) / 64) % 2) == 0;
  endfunction

  task automatic chk_out(input logic sel, input string tag, input logic [6:0] s,
                         input logic [1:0] de, input logic [1:0] dr, input logic e);
    if (!sel) begin
      chk({tag, ".seg"}, 32'(seg_a), 32'(s));
      chk({tag, ".digit_en"}, 32'(den_a), 32'(de));
      chk({tag, ".dir"}, 32'(dir_a), 32'(dr));
      chk({tag, ".err"}, 32'(err_a), 32'(e));
    end else begin
      chk({tag, ".seg"}, 32'(seg_b), 32'(s));
      chk({tag, ".digit_en"}, 32'(den_b), 32'(de));
      chk({tag, ".dir"}, 32'(dir_b), 32'(dr));
      chk({tag, ".err"}, 32'(err_b), 32'(e));
    end
  endtask

  task automatic frame(input logic sel, input string tag, input logic [6:0] d0,
                       input logic [6:0] d1, input logic [1:0] dr, input logic e, input int n);
    int idx;
    for (int i = 0; i < n; i++) begin
      step();
      idx = exp_idx(cyc);
      chk_out(sel, tag, (idx == 1) ? d1 : d0, 2'(1 << idx), dr, e);
    end
  endtask

  // One capture edge on the default DUT, then dir/err checked right after it.
  task automatic cap_a(input logic [3:0] f, input string tag, input logic [1:0] dr, input logic e);
    fv_a = 1'b1;
    fl_a = f;
    step();
    fv_a = 1'b0;
    chk({tag, ".dir"}, 32'(dir_a), 32'(dr));
    chk({tag, ".err"}, 32'(err_a), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    //            sel   fv    fl     d0     d1     dir    err
    vecs[0]  = '{1'b0, 1'b1, 4'd0,  7'h3F, 7'h00, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,  7'h4F, 7'h00, 2'b01, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'd12, 7'h5B, 7'h06, 2'b01, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'd7,  7'h07, 7'h00, 2'b10, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd6,  7'h7D, 7'h00, 2'b01, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'd6,  7'h7D, 7'h00, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd9,  7'h7D, 7'h00, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd9,  7'h6F, 7'h00, 2'b01, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd2,  7'h5B, 7'h00, 2'b10, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd1,  7'h06, 7'h00, 2'b10, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 4'd5,  7'h6D, 7'h00, 2'b01, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'd8,  7'h7F, 7'h00, 2'b01, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd3,  7'h4F, 7'h00, 2'b10, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 4'd4,  7'h66, 7'h00, 2'b01, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'd10, 7'h3F, 7'h06, 2'b01, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'd15, 7'h6D, 7'h06, 2'b01, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 4'd0,  7'h3F, 7'h00, 2'b10, 1'b0};

    // Reset held with a coincident capture request.
    reset = 1'b0;
    fv_a = 1'b1; fl_a = 4'd5;
    fv_b = 1'b1; fl_b = 4'd5;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out(1'b0, "rst_a", 7'h00, 2'b00, 2'b00, 1'b0);
      chk_out(1'b1, "rst_b", 7'h00, 2'b00, 2'b00, 1'b0);
    end
    #2;
    reset = 1'b1;
    fv_a = 1'b0; fv_b = 1'b0;
    cyc = 0;
    step();
    chk_out(1'b0, "rel_a", 7'h3F, 2'b01, 2'b00, 1'b0);
    chk_out(1'b1, "rel_b", 7'h3F, 2'b01, 2'b00, 1'b0);
    frame(1'b0, "post_rst", 7'h3F, 7'h00, 2'b00, 1'b0, 7);

    // Directed vectors: one capture edge, then a full scan frame.
    foreach (vecs[v]) begin
      if (!vecs[v].sel) begin
        fv_a = vecs[v].fv; fl_a = vecs[v].fl;
      end else begin
        fv_b = vecs[v].fv; fl_b = vecs[v].fl;
      end
      step();
      fv_a = 1'b0; fv_b = 1'b0;
      if (!vecs[v].sel) begin
        chk($sformatf("vec%0d.dir", v), 32'(dir_a), 32'(vecs[v].dir));
        chk($sformatf("vec%0d.err", v), 32'(err_a), 32'(vecs[v].err));
      end else begin
        chk($sformatf("vec%0d.dir", v), 32'(dir_b), 32'(vecs[v].dir));
        chk($sformatf("vec%0d.err", v), 32'(err_b), 32'(vecs[v].err));
      end
      frame(vecs[v].sel, $sformatf("vec%0d", v), vecs[v].d0, vecs[v].d1,
            vecs[v].dir, vecs[v].err, 8);
    end

    // Out-of-range capture aligned so the next edge starts a blink-on half-period.
    while (((cyc + 1) % 128) != 0) step();
    cap_a(4'd12, "err12", 2'b01, 1'b1);
    for (int i = 0; i < 64; i++) begin
      step();
      idx = exp_idx(cyc);
      chk_out(1'b0, "blink_on", 7'h79, 2'(1 << idx), 2'b01, 1'b1);
    end
    for (int i = 0; i < 64; i++) begin
      step();
      idx = exp_idx(cyc);
      chk_out(1'b0, "blink_off", 7'h00, 2'(1 << idx), 2'b01, 1'b1);
    end
    cap_a(4'd4, "recover4", 2'b00, 1'b0);
    frame(1'b0, "recover4", 7'h66, 7'h00, 2'b00, 1'b0, 8);

    // Recovery from error during blink-off.
    cap_a(4'd15, "err15", 2'b00, 1'b1);
    while (exp_blink(cyc + 1)) step();
    cap_a(4'd2, "recover2", 2'b10, 1'b0);
    frame(1'b0, "recover2", 7'h5B, 7'h00, 2'b10, 1'b0, 8);

    // floor == NUM_FLOORS is out of range; then async reset during blink-on.
    cap_a(4'd10, "err10", 2'b10, 1'b1);
    while (!exp_blink(cyc + 1)) step();
    for (int i = 0; i < 3; i++) begin
      step();
      idx = exp_idx(cyc);
      chk_out(1'b0, "pre_rst_e", 7'h79, 2'(1 << idx), 2'b10, 1'b1);
    end
    #2;
    reset = 1'b0;
    fv_a = 1'b1; fl_a = 4'd5;
    #1;
    chk_out(1'b0, "async_rst", 7'h00, 2'b00, 2'b00, 1'b0);
    step();
    chk_out(1'b0, "rst_hold", 7'h00, 2'b00, 2'b00, 1'b0);
    #2;
    reset = 1'b1;
    fv_a = 1'b0;
    cyc = 0;
    step();
    chk_out(1'b0, "rel2", 7'h3F, 2'b01, 2'b00, 1'b0);
    frame(1'b0, "post_rst2", 7'h3F, 7'h00, 2'b00, 1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/floor_display_scan.md
FLOOR_DISPLAY_SCAN -- requirements
Module: floor_display_scan

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 10, number of valid floors (0..NUM_FLOORS-1).
REQ-002 The block SHALL have parameter FLOOR_W, default 4, floor input width; NUM_FLOORS <= 2**FLOOR_W.
REQ-003 The block SHALL have parameter DIGITS, default 2, number of multiplexed 7-segment digits; NUM_FLOORS <= 10**DIGITS.
REQ-004 The block SHALL have parameter SCAN_DIV, default 4, clocks per digit slot; SCAN_DIV >= 1.
REQ-005 The block SHALL have parameter BLINK_DIV, default 8, scan frames per blink half-period; BLINK_DIV >= 1.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous, active-low reset (0 = in reset).
REQ-008 The block SHALL have port floor, input, FLOOR_W, binary floor number from the elevator FSM.
REQ-009 The block SHALL have port floor_valid, input, 1, capture strobe; floor is sampled on each edge where it is 1.
REQ-010 The block SHALL have port seg, output, 7, registered segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-011 The block SHALL have port digit_en, output, DIGITS, registered one-hot digit enable; bit 0 = least-significant digit.
REQ-012 The block SHALL have port dir, output, 2, registered direction: 00 idle, 01 up, 10 down; 11 never driven.
REQ-013 The block SHALL have port err, output, 1, registered out-of-range flag.

Function
REQ-014 On an edge with floor_valid=1 and floor < NUM_FLOORS, the block SHALL load the internal shown floor, clear err, and set dir to 01/10/00 for new >/</= the previous shown floor.
REQ-015 On an edge with floor_valid=1 and floor >= NUM_FLOORS, the block SHALL set err=1 and keep the shown floor and dir unchanged.
REQ-016 With floor_valid=0 the block SHALL hold the shown floor, dir and err.
REQ-017 The block SHALL convert the shown floor to DIGITS BCD digits combinationally; the division operator is not used.
REQ-018 The block SHALL run a scan counter 0..SCAN_DIV-1 and, on its wrap, advance the digit index 0..DIGITS-1, wrapping to 0.
REQ-019 The block SHALL keep digit_en scanning in every mode, including error mode.
REQ-020 The block SHALL register seg and digit_en so both reflect the current digit index and the state present one edge earlier; a capture at edge k shows at edge k+1 for the active digit.
REQ-021 The block SHALL use segment codes 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,E=79 (hex).
REQ-022 The block SHALL blank (seg=00) every digit above the most significant nonzero digit; digit 0 always displays, including value 0.
REQ-023 The block SHALL toggle a blink phase each time BLINK_DIV complete frames (DIGITS*SCAN_DIV clocks each) have elapsed; the phase counter runs continuously.
REQ-024 With err=1 the block SHALL drive seg=79 on every digit during blink-on phase and seg=00 during blink-off phase.
REQ-025 A valid capture during error mode SHALL resume normal display at the next edge regardless of blink phase.

Reset
REQ-026 While reset=0 the block SHALL immediately and asynchronously force seg=00, digit_en=0, dir=00, err=0, shown floor=0, scan counter=0, digit index=0, blink counters=0, blink phase=on.
REQ-027 Reset asserted mid-operation, including in error mode, SHALL take effect without waiting for a clock edge and override a coincident floor_valid.
REQ-028 At the first edge after reset=1 the block SHALL output digit_en=...01 and seg=3F.

Verification
REQ-029 Reset: reset=0 for 3 cycles with floor_valid=1, floor=5 -> seg=00, digit_en=0, dir=00, err=0; release -> next edge digit_en=01, seg=3F.
REQ-030 Up move (defaults): capture 0 then 3 -> dir=01; digit 0 slot seg=4F, digit 1 slot seg=00 (blanked); each slot lasts 4 clocks.
REQ-031 Two digits (NUM_FLOORS=16): capture 12 -> digit0 seg=5B, digit1 seg=06; then capture 7 -> dir=10, digit0 seg=07, digit1 seg=00.
REQ-032 Invalid (defaults): shown 4, capture 12 -> err=1, dir unchanged, seg=79 on both slots for 8 frames (64 clocks), then 00 for 64 clocks; capture 4 -> err=0, dir=00, seg=66 next edge.
REQ-033 Equal floor: shown 6, capture 6 -> dir=00, display unchanged; floor_valid=0 with floor=9 -> no change.
REQ-034 Async reset mid-error: reset=0 between edges during blink-on -> seg=00, err=0 immediately, before the next rising clk.
